// File: rtl/dmem_bridge.sv
// Data-memory bridge between the MEM pipeline stage and a req/addr_ok/data_ok bus.
// Issues one bus request per MEM instruction and stalls the pipeline until it completes.
module dmem_bridge #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_en_i,
  input  logic              mem_wr_i,
  input  logic [1:0]        mem_size_i,
  input  logic [DATA_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  input  logic              cpu_stall_i,
  input  logic              flush_i,
  output logic              mem_stall_o,
  output logic [DATA_W-1:0] mem_rdata_o,
  output logic              data_req_o,
  output logic              data_wr_o,
  output logic [1:0]        data_size_o,
  output logic [DATA_W-1:0] data_addr_o,
  output logic [DATA_W-1:0] data_wdata_o,
  input  logic              data_addr_ok_i,
  input  logic              data_data_ok_i,
  input  logic [DATA_W-1:0] data_rdata_i
);

  localparam int LANES = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            state_reg, state_next;
  logic              discard_reg, discard_next;
  logic              wr_reg;
  logic [1:0]        size_reg;
  logic [DATA_W-1:0] addr_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic [DATA_W-1:0] rdata_reg;

  logic              capture;
  logic              complete;
  logic              drop;
  logic              stall_comb;
  logic [LANES-1:0][7:0] wdata_lanes;

  // Replicate right-aligned store data so every byte lane carries the value.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign wdata_lanes[gi] = (mem_size_i == 2'd0) ? mem_wdata_i[7:0] :
                             (mem_size_i == 2'd1) ? mem_wdata_i[(gi % 2) * 8 +: 8] :
                                                    mem_wdata_i[gi * 8 +: 8];
  end

  // A flush arriving in the same cycle as completion still cancels the access.
  assign drop = discard_reg | flush_i;

  always_comb begin
    state_next   = state_reg;
    discard_next = discard_reg;
    capture      = 1'b0;
    complete     = 1'b0;
    stall_comb   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (mem_en_i && !flush_i) begin
          capture    = 1'b1;
          stall_comb = 1'b1;
          state_next = REQ;
        end
      end
      REQ: begin
        stall_comb   = 1'b1;
        discard_next = drop;
        if (data_addr_ok_i) begin
          if (data_data_ok_i) begin
            complete     = 1'b1;
            discard_next = 1'b0;
            state_next   = drop ? IDLE : DONE;
          end else begin
            state_next = WAIT;
          end
        end
      end
      WAIT: begin
        stall_comb   = 1'b1;
        discard_next = drop;
        if (data_data_ok_i) begin
          complete     = 1'b1;
          discard_next = 1'b0;
          state_next   = drop ? IDLE : DONE;
        end
      end
      DONE: begin
        if (!cpu_stall_i || flush_i) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= IDLE;
      discard_reg <= 1'b0;
      wr_reg      <= 1'b0;
      size_reg    <= 2'd0;
      addr_reg    <= '0;
      wdata_reg   <= '0;
      rdata_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      discard_reg <= discard_next;
      if (capture) begin
        wr_reg    <= mem_wr_i;
        size_reg  <= mem_size_i;
        addr_reg  <= mem_addr_i;
        wdata_reg <= wdata_lanes;
      end
      if (complete && !drop) begin
        rdata_reg <= data_rdata_i;
      end
    end
  end

  // Stall is gated by reset so every output reads zero while reset is held.
  assign mem_stall_o  = rst & stall_comb;
  assign mem_rdata_o  = rdata_reg;
  assign data_req_o   = (state_reg == REQ);
  assign data_wr_o    = wr_reg;
  assign data_size_o  = size_reg;
  assign data_addr_o  = addr_reg;
  assign data_wdata_o = wdata_reg;

  a_req_held: assert property (@(posedge clk) disable iff (!rst)
    (state_reg == REQ && !data_addr_ok_i) |=> (state_reg == REQ && $stable(addr_reg)
                                               && $stable(wdata_reg) && $stable(size_reg)));

endmodule

// File: tb/tb_dmem_bridge.sv
// Self-checking bench for dmem_bridge: directed vector table, hand-written corner
// sequences, and a randomized run against a transaction-level reference model.
module tb_dmem_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        en, wr, cst, fl, aok, dok;
  logic [1:0]  sz;
  logic [31:0] addr, wdata, rdata_in;
  logic        stall_o, req_o, wr_o;
  logic [1:0]  size_o;
  logic [31:0] rdata_o, addr_o, wdata_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_bridge #(.DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .mem_en_i(en), .mem_wr_i(wr), .mem_size_i(sz), .mem_addr_i(addr),
    .mem_wdata_i(wdata), .cpu_stall_i(cst), .flush_i(fl),
    .mem_stall_o(stall_o), .mem_rdata_o(rdata_o),
    .data_req_o(req_o), .data_wr_o(wr_o), .data_size_o(size_o),
    .data_addr_o(addr_o), .data_wdata_o(wdata_o),
    .data_addr_ok_i(aok), .data_data_ok_i(dok), .data_rdata_i(rdata_in)
  );

  typedef struct {
    logic        en, wr;
    logic [1:0]  sz;
    logic [31:0] addr, wdata;
    logic        cst, fl, aok, dok;
    logic [31:0] rd;
    logic        e_req, e_stall;
    logic [31:0] e_rd;
    logic        e_wr;
    logic [1:0]  e_size;
    logic [31:0] e_addr, e_wdata;
  } vec_t;

  vec_t vq[$];

  // reference model state
  logic        m_req, m_wait, m_hold, m_drop, m_wr;
  logic [1:0]  m_size;
  logic [31:0] m_addr, m_wdata, m_rdata;
  int          txn_count = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic e, w, input logic [1:0] s, input logic [31:0] a, d,
                       input logic c, f, ao, dk, input logic [31:0] r);
    en = e; wr = w; sz = s; addr = a; wdata = d;
    cst = c; fl = f; aok = ao; dok = dk; rdata_in = r;
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic step_chk(input string tag, input logic e_req, e_stall, input logic [31:0] e_rd);
    @(negedge clk);
    chk({tag, "_req"}, {31'd0, req_o}, {31'd0, e_req});
    chk({tag, "_stall"}, {31'd0, stall_o}, {31'd0, e_stall});
    chk({tag, "_rdata"}, rdata_o, e_rd);
    next_cycle();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req"}, {31'd0, req_o}, 32'd0);
    chk({tag, "_stall"}, {31'd0, stall_o}, 32'd0);
    chk({tag, "_rdata"}, rdata_o, 32'd0);
    chk({tag, "_addr"}, addr_o, 32'd0);
    chk({tag, "_wdata"}, wdata_o, 32'd0);
    chk({tag, "_size"}, {30'd0, size_o}, 32'd0);
    chk({tag, "_wr"}, {31'd0, wr_o}, 32'd0);
  endtask

  task automatic add_vec(input logic e, w, input logic [1:0] s, input logic [31:0] a, d,
                         input logic c, f, ao, dk, input logic [31:0] r,
                         input logic x_req, x_stall, input logic [31:0] x_rd,
                         input logic x_wr, input logic [1:0] x_size,
                         input logic [31:0] x_addr, x_wdata);
    vec_t v;
    v.en = e; v.wr = w; v.sz = s; v.addr = a; v.wdata = d;
    v.cst = c; v.fl = f; v.aok = ao; v.dok = dk; v.rd = r;
    v.e_req = x_req; v.e_stall = x_stall; v.e_rd = x_rd;
    v.e_wr = x_wr; v.e_size = x_size; v.e_addr = x_addr; v.e_wdata = x_wdata;
    vq.push_back(v);
  endtask

  function automatic logic [31:0] lanes(input logic [1:0] s, input logic [31:0] w);
    case (s)
      2'd0:    return (w & 32'h0000_00FF) * 32'h0101_0101;
      2'd1:    return (w & 32'h0000_FFFF) * 32'h0001_0001;
      default: return w;
    endcase
  endfunction

  task automatic model_reset;
    m_req = 0; m_wait = 0; m_hold = 0; m_drop = 0; m_wr = 0;
    m_size = 0; m_addr = 0; m_wdata = 0; m_rdata = 0;
  endtask

  task automatic model_finish(input logic dropped, input logic [31:0] r);
    m_req = 0; m_wait = 0; m_drop = 0;
    txn_count++;
    if (!dropped) begin
      m_rdata = r;
      m_hold  = 1;
    end
    $display("txn %0d addr=0x%08h wr=%0d size=%0d %s", txn_count, m_addr, m_wr, m_size,
             dropped ? "discarded" : "completed");
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_step;
    logic idle, drop;
    idle = !m_req && !m_wait && !m_hold;
    drop = m_drop || fl;
    if (idle) begin
      if (en && !fl) begin
        m_req = 1; m_wr = wr; m_size = sz; m_addr = addr; m_wdata = lanes(sz, wdata);
      end
    end else if (m_req) begin
      if (aok && dok) model_finish(drop, rdata_in);
      else if (aok) begin m_req = 0; m_wait = 1; m_drop = drop; end
      else m_drop = drop;
    end else if (m_wait) begin
      if (dok) model_finish(drop, rdata_in);
      else m_drop = drop;
    end else begin
      if (!cst || fl) m_hold = 0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected finish before it");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0]  b2b_req, b2b_stall;
    int          reqs;
    logic        r_en, r_wr, r_cst, r_fl, r_aok, r_dok, idle;
    logic [1:0]  r_sz;

    // reset: outputs must be zero even with an access presented
    rst = 1'b0;
    drive(1, 0, 2, 32'h8000_0010, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk_all_zero("reset");
    next_cycle();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    next_cycle();

    // load word then store byte, half store, spurious data_ok in IDLE/DONE
    add_vec(1,0,2,32'h8000_0010,0,          0,0,0,0,0,            0,1,0,            0,0,0,0);
    add_vec(1,0,2,32'h8000_0010,0,          0,0,0,0,0,            1,1,0,            0,2,32'h8000_0010,0);
    add_vec(1,0,2,32'h8000_0010,0,          0,0,1,0,0,            1,1,0,            0,2,32'h8000_0010,0);
    add_vec(1,0,2,32'h8000_0010,0,          0,0,0,1,32'h1234_5678,0,1,0,            0,2,32'h8000_0010,0);
    add_vec(1,0,2,32'h8000_0010,0,          0,0,0,0,0,            0,0,32'h1234_5678,0,2,32'h8000_0010,0);
    add_vec(0,0,0,0,0,                      0,0,0,0,0,            0,0,32'h1234_5678,0,2,32'h8000_0010,0);
    add_vec(1,1,0,32'h0000_0103,32'h0000_00AB,0,0,0,0,0,          0,1,32'h1234_5678,0,2,32'h8000_0010,0);
    add_vec(1,1,0,32'h0000_0103,32'h0000_00AB,0,0,1,1,32'hDEAD_BEEF,1,1,32'h1234_5678,1,0,32'h0000_0103,32'hABAB_ABAB);
    add_vec(1,1,0,32'h0000_0103,32'h0000_00AB,0,0,0,1,32'h1111_1111,0,0,32'hDEAD_BEEF,1,0,32'h0000_0103,32'hABAB_ABAB);
    add_vec(0,0,0,0,0,                      0,0,0,1,32'h2222_2222,0,0,32'hDEAD_BEEF,1,0,32'h0000_0103,32'hABAB_ABAB);
    add_vec(1,1,1,32'h0000_0202,32'h1234_BEEF,0,0,0,0,0,          0,1,32'hDEAD_BEEF,1,0,32'h0000_0103,32'hABAB_ABAB);
    add_vec(1,1,1,32'h0000_0202,32'h1234_BEEF,0,0,1,0,0,          1,1,32'hDEAD_BEEF,1,1,32'h0000_0202,32'hBEEF_BEEF);
    add_vec(1,1,1,32'h0000_0202,32'h1234_BEEF,0,0,0,1,32'hDEAD_BEEF,0,1,32'hDEAD_BEEF,1,1,32'h0000_0202,32'hBEEF_BEEF);
    add_vec(0,0,0,0,0,                      0,0,0,0,0,            0,0,32'hDEAD_BEEF,1,1,32'h0000_0202,32'hBEEF_BEEF);
    add_vec(0,0,0,0,0,                      0,0,0,0,0,            0,0,32'hDEAD_BEEF,1,1,32'h0000_0202,32'hBEEF_BEEF);

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].en, vq[i].wr, vq[i].sz, vq[i].addr, vq[i].wdata,
            vq[i].cst, vq[i].fl, vq[i].aok, vq[i].dok, vq[i].rd);
      @(negedge clk);
      chk($sformatf("vec%0d_req", i), {31'd0, req_o}, {31'd0, vq[i].e_req});
      chk($sformatf("vec%0d_stall", i), {31'd0, stall_o}, {31'd0, vq[i].e_stall});
      chk($sformatf("vec%0d_rdata", i), rdata_o, vq[i].e_rd);
      chk($sformatf("vec%0d_wr", i), {31'd0, wr_o}, {31'd0, vq[i].e_wr});
      chk($sformatf("vec%0d_size", i), {30'd0, size_o}, {30'd0, vq[i].e_size});
      chk($sformatf("vec%0d_addr", i), addr_o, vq[i].e_addr);
      chk($sformatf("vec%0d_wdata", i), wdata_o, vq[i].e_wdata);
      $display("vec %0d req=%0d stall=%0d rdata=0x%08h", i, req_o, stall_o, rdata_o);
      next_cycle();
    end

    // load completes while the pipeline is held: DONE holds, no second request
    drive(1, 0, 2, 32'h4, 0, 0, 0, 0, 0, 0);            step_chk("hold_idle", 0, 1, 32'hDEAD_BEEF);
    drive(1, 0, 2, 32'h4, 0, 1, 0, 1, 1, 32'hCAFE_F00D); step_chk("hold_req", 1, 1, 32'hDEAD_BEEF);
    for (int k = 0; k < 3; k++) begin
      drive(1, 0, 2, 32'h4, 0, 1, 0, 0, (k == 1), 32'h5555_5555);
      step_chk($sformatf("hold_done%0d", k), 0, 0, 32'hCAFE_F00D);
    end
    drive(1, 0, 2, 32'h4, 0, 0, 0, 0, 0, 0);            step_chk("hold_release", 0, 0, 32'hCAFE_F00D);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);                step_chk("hold_after", 0, 0, 32'hCAFE_F00D);
    $display("seq hold_in_done finished");

    // flush pulse in WAIT: stall held until data_ok, result discarded
    drive(1, 0, 2, 32'h8, 0, 0, 0, 0, 0, 0);            step_chk("fl_idle", 0, 1, 32'hCAFE_F00D);
    drive(1, 0, 2, 32'h8, 0, 0, 0, 1, 0, 0);            step_chk("fl_req", 1, 1, 32'hCAFE_F00D);
    drive(1, 0, 2, 32'h8, 0, 0, 1, 0, 0, 0);            step_chk("fl_wait_flush", 0, 1, 32'hCAFE_F00D);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);                step_chk("fl_wait_hold", 0, 1, 32'hCAFE_F00D);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hBAD0_BAD0);    step_chk("fl_data_ok", 0, 1, 32'hCAFE_F00D);
    drive(1, 0, 2, 32'hC, 0, 1, 0, 0, 0, 0);            step_chk("fl_back_idle", 0, 1, 32'hCAFE_F00D);
    drive(1, 0, 2, 32'hC, 0, 0, 0, 1, 1, 32'h0F0F_0F0F); step_chk("fl_next_req", 1, 1, 32'hCAFE_F00D);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);                step_chk("fl_next_done", 0, 0, 32'h0F0F_0F0F);
    $display("seq flush_in_wait finished");

    // reset asserted in WAIT, then a fresh request after release
    drive(1, 1, 2, 32'h30, 32'h99, 0, 0, 0, 0, 0);      step_chk("rw_idle", 0, 1, 32'h0F0F_0F0F);
    drive(1, 1, 2, 32'h30, 32'h99, 0, 0, 1, 0, 0);      step_chk("rw_req", 1, 1, 32'h0F0F_0F0F);
    drive(1, 1, 2, 32'h30, 32'h99, 0, 0, 0, 0, 0);
    rst = 1'b0;
    #1;
    chk_all_zero("rw_in_reset");
    next_cycle();
    rst = 1'b1;
    drive(1, 0, 2, 32'h10, 0, 0, 0, 0, 0, 0);           step_chk("rw_release", 0, 1, 32'h0);
    drive(1, 0, 2, 32'h10, 0, 0, 0, 1, 1, 32'h7777_7777); step_chk("rw_fresh_req", 1, 1, 32'h0);
    chk("rw_fresh_addr", addr_o, 32'h10);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);                step_chk("rw_done", 0, 0, 32'h7777_7777);
    $display("seq reset_in_wait finished");

    // back-to-back load then store
    b2b_req   = 6'b010010;
    b2b_stall = 6'b011011;
    reqs = 0;
    for (int c = 0; c < 6; c++) begin
      case (c)
        0, 2:    drive(1, 0, 2, 32'h20, 0, 0, 0, 0, 0, 0);
        1:       drive(1, 0, 2, 32'h20, 0, 0, 0, 1, 1, 32'hA1A1_A1A1);
        3:       drive(1, 1, 2, 32'h24, 32'h5A5A_1234, 0, 0, 0, 0, 0);
        4:       drive(1, 1, 2, 32'h24, 32'h5A5A_1234, 0, 0, 1, 1, 32'hB2B2_B2B2);
        default: drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      endcase
      @(negedge clk);
      if (req_o) reqs++;
      chk($sformatf("b2b%0d_req", c), {31'd0, req_o}, {31'd0, b2b_req[c]});
      chk($sformatf("b2b%0d_stall", c), {31'd0, stall_o}, {31'd0, b2b_stall[c]});
      next_cycle();
    end
    chk("b2b_req_count", reqs, 2);
    chk("b2b_addr", addr_o, 32'h24);
    chk("b2b_wdata", wdata_o, 32'h5A5A_1234);
    chk("b2b_rdata", rdata_o, 32'hB2B2_B2B2);
    $display("seq back_to_back finished");

    // randomized run against the reference model
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    next_cycle();
    rst = 1'b1;
    model_reset();
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        rst = 1'b0;
        #1;
        chk("rand_reset_req", {31'd0, req_o}, 32'd0);
        chk("rand_reset_stall", {31'd0, stall_o}, 32'd0);
        chk("rand_reset_rdata", rdata_o, 32'd0);
        model_reset();
        next_cycle();
        rst = 1'b1;
      end
      idle  = !m_req && !m_wait && !m_hold;
      r_en  = ($urandom_range(0, 3) != 0);
      r_wr  = 1'($urandom_range(0, 1));
      r_sz  = 2'($urandom_range(0, 2));
      r_cst = 1'($urandom_range(0, 1));
      r_fl  = ($urandom_range(0, 9) == 0);
      r_aok = m_req ? ($urandom_range(0, 2) != 0) : 1'($urandom_range(0, 1));
      if (m_req)       r_dok = r_aok && ($urandom_range(0, 1) == 1);
      else if (m_wait) r_dok = ($urandom_range(0, 2) == 0);
      else             r_dok = ($urandom_range(0, 6) == 0);
      drive(r_en, r_wr, r_sz, $urandom, $urandom, r_cst, r_fl, r_aok, r_dok, $urandom);
      @(negedge clk);
      chk("rand_req", {31'd0, req_o}, {31'd0, m_req});
      chk("rand_stall", {31'd0, stall_o},
          {31'd0, (idle && r_en && !r_fl) || m_req || m_wait});
      chk("rand_rdata", rdata_o, m_rdata);
      chk("rand_wr", {31'd0, wr_o}, {31'd0, m_wr});
      chk("rand_size", {30'd0, size_o}, {30'd0, m_size});
      chk("rand_addr", addr_o, m_addr);
      chk("rand_wdata", wdata_o, m_wdata);
      model_step();
      next_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
